// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types for the sprite ROM arbiter.
// Rev 1.0
`default_nettype none

package sprite_pkg;
    localparam int SPR_ADDR_W  = 8;
    localparam int SPR_DATA_W  = 4;
    // The index type is sized for the largest legal requester count (8).
    localparam int SPR_MAX_REQ = 8;

    typedef logic [$clog2(SPR_MAX_REQ)-1:0] req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t idx;
    } rd_tag_t;
endpackage

`default_nettype wire

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder, first set req bit at or after ptr (wrapping).
// Rev 1.0
`default_nettype none

module rr_pick
    import sprite_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         ptr,
    output logic [N_REQ-1:0] onehot,
    output req_idx_t         idx,
    output logic             any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        // Upper segment [ptr..N_REQ-1] first, then wrap to [0..ptr-1].
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i] && (req_idx_t'(i) >= ptr)) begin
                any = 1'b1;
                idx = req_idx_t'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i]) begin
                any = 1'b1;
                idx = req_idx_t'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            onehot[i] = any && (idx == req_idx_t'(i));
        end
    end

endmodule

`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin share of one sprite ROM with burst lock and tagged read return.
// Rev 1.0
`default_nettype none

module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = SPR_ADDR_W,
    parameter int DATA_W    = SPR_DATA_W,
    parameter int ROM_LAT   = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                    vga_clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rom_address,
    input  logic [DATA_W-1:0]       rom_q,
    output logic [N_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]       rd_data
);

    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam req_idx_t         LAST_IDX  = req_idx_t'(N_REQ - 1);

    req_idx_t         rr_ptr;
    req_idx_t         owner;
    logic             owner_valid;
    logic [CNT_W-1:0] burst_cnt;
    rd_tag_t          tag_pipe [ROM_LAT];

    logic [N_REQ-1:0] pick_onehot;
    req_idx_t         pick_idx;
    logic             pick_any;
    logic [N_REQ-1:0] owner_onehot;
    logic             owner_req;
    logic             lock_hit;
    logic             grant_any;
    logic             grant_lock;
    req_idx_t         winner;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            owner_onehot[i] = (owner == req_idx_t'(i));
        end
    end

    assign owner_req = |(req & owner_onehot);
    // A saturated burst counter drops the owner back to plain round-robin.
    assign lock_hit  = owner_valid && owner_req && (burst_cnt < BURST_MAX);
    assign grant_any = reset_n && (lock_hit || pick_any);
    assign winner    = lock_hit ? owner : pick_idx;
    assign gnt       = !reset_n ? '0 : (lock_hit ? owner_onehot : pick_onehot);
    assign grant_lock = |(lock & gnt);

    always_comb begin
        rom_address = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                rom_address = addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr      <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            burst_cnt   <= '0;
        end else if (grant_any) begin
            rr_ptr <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
            if (grant_lock) begin
                owner_valid <= 1'b1;
                owner       <= winner;
                burst_cnt   <= lock_hit ? burst_cnt + 1'b1 : CNT_W'(1);
            end else begin
                owner_valid <= 1'b0;
                burst_cnt   <= '0;
            end
        end else begin
            owner_valid <= 1'b0;
            burst_cnt   <= '0;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0].valid <= grant_any;
            tag_pipe[0].idx   <= winner;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            rd_valid[i] = tag_pipe[ROM_LAT-1].valid &&
                          (tag_pipe[ROM_LAT-1].idx == req_idx_t'(i));
        end
    end

    assign rd_data = rom_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed and randomized checks of two arbiter instances (ROM_LAT 1 and 3).
// Rev 1.0
`default_nettype none

module tb_sprite_rom_arbiter;
    localparam int MAX_BURST = 8;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] addr;
    logic [3:0]  gnt1, gnt3, rv1, rv3, q1, q3, rd1, rd3;
    logic [7:0]  ra1, ra3;
    logic [3:0]  p3 [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_rr, m_owner, m_cnt, m_win;
    int         g_hist [4];
    logic [3:0] d_hist [4];
    logic [3:0] exp_gnt, exp_rv1, exp_rd1, exp_rv3, exp_rd3;
    logic [7:0] exp_addr;

    sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(4), .ROM_LAT(1), .MAX_BURST(MAX_BURST)) dut1 (
        .vga_clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .addr(addr),
        .gnt(gnt1), .rom_address(ra1), .rom_q(q1), .rd_valid(rv1), .rd_data(rd1));

    sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(4), .ROM_LAT(3), .MAX_BURST(MAX_BURST)) dut3 (
        .vga_clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .addr(addr),
        .gnt(gnt3), .rom_address(ra3), .rom_q(q3), .rd_valid(rv3), .rd_data(rd3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM models return the low nibble of the address after their latency.
    always @(posedge clk) q1 <= ra1[3:0];
    always @(posedge clk) begin
        p3[0] <= ra3[3:0];
        p3[1] <= p3[0];
        q3    <= p3[1];
    end

    task automatic model_reset();
        m_rr = 0; m_owner = -1; m_cnt = 0; m_win = -1;
        for (int s = 0; s < 4; s++) begin g_hist[s] = -1; d_hist[s] = 4'h0; end
    endtask

    task automatic model_eval();
        int w;
        w = -1;
        if (reset_n === 1'b1) begin
            if (m_owner >= 0 && req[m_owner] && m_cnt < MAX_BURST) w = m_owner;
            else for (int o = 0; o < 4; o++) if (w < 0 && req[(m_rr + o) % 4]) w = (m_rr + o) % 4;
        end
        m_win    = w;
        exp_gnt  = (w >= 0) ? 4'(1 << w) : 4'b0;
        exp_addr = (w >= 0) ? addr[w*8 +: 8] : 8'h00;
        exp_rv1  = (g_hist[1] >= 0) ? 4'(1 << g_hist[1]) : 4'b0;
        exp_rd1  = d_hist[1];
        exp_rv3  = (g_hist[3] >= 0) ? 4'(1 << g_hist[3]) : 4'b0;
        exp_rd3  = d_hist[3];
    endtask

    task automatic model_commit();
        if (m_win >= 0) begin
            if (lock[m_win]) begin
                m_cnt   = (m_owner == m_win && m_cnt < MAX_BURST) ? m_cnt + 1 : 1;
                m_owner = m_win;
            end else begin
                m_owner = -1; m_cnt = 0;
            end
            m_rr = (m_win + 1) % 4;
        end else begin
            m_owner = -1; m_cnt = 0;
        end
        for (int s = 3; s > 1; s--) begin g_hist[s] = g_hist[s-1]; d_hist[s] = d_hist[s-1]; end
        g_hist[1] = m_win;
        d_hist[1] = (m_win >= 0) ? addr[m_win*8 +: 4] : 4'h0;
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = 4'b1111; lock = 4'b0000; addr = 32'h28_1E_14_0A;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++; if (gnt1 !== 4'b0 || gnt3 !== 4'b0) begin n_fail++; $display("FAIL reset_gnt: got %b/%b expected 0000", gnt1, gnt3); end
            n_tests++; if (rv1 !== 4'b0 || rv3 !== 4'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b/%b expected 0000", rv1, rv3); end
            n_tests++; if (ra1 !== 8'h00) begin n_fail++; $display("FAIL reset_rom_address: got %h expected 00", ra1); end
        end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk); model_eval();
        n_tests++; if (gnt1 !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt1); end
        advance();
    endtask

    task automatic test_round_robin();
        logic [3:0] g_seq [5];
        logic [3:0] v_seq [5];
        logic [3:0] d_seq [5];
        g_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        v_seq = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        d_seq = '{4'h0, 4'hA, 4'h4, 4'hE, 4'h8};
        req = 4'b1111; lock = 4'b0000; addr = 32'h28_1E_14_0A;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); model_eval();
            n_tests++; if (gnt1 !== g_seq[c]) begin n_fail++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, gnt1, g_seq[c]); end
            n_tests++; if (rv1 !== v_seq[c]) begin n_fail++; $display("FAIL rr_rd_valid c%0d: got %b expected %b", c, rv1, v_seq[c]); end
            if (c > 0) begin
                n_tests++; if (rd1 !== d_seq[c]) begin n_fail++; $display("FAIL rr_rd_data c%0d: got %h expected %h", c, rd1, d_seq[c]); end
            end
            n_tests++; if (ra1 !== exp_addr) begin n_fail++; $display("FAIL rr_rom_address c%0d: got %h expected %h", c, ra1, exp_addr); end
            advance();
        end
    endtask

    task automatic test_burst();
        logic [3:0] want;
        req = 4'b0011; lock = 4'b0001; addr = $urandom;
        apply_reset();
        for (int c = 0; c < 19; c++) begin
            @(negedge clk); model_eval();
            want = (c == 8 || c == 17) ? 4'b0010 : 4'b0001;
            n_tests++; if (gnt1 !== want) begin n_fail++; $display("FAIL burst_gnt c%0d: got %b expected %b", c, gnt1, want); end
            n_tests++; if (rv1 !== exp_rv1 || rv3 !== exp_rv3) begin n_fail++; $display("FAIL burst_rd_valid c%0d: got %b/%b expected %b/%b", c, rv1, rv3, exp_rv1, exp_rv3); end
            advance();
        end
    endtask

    task automatic test_abandon();
        req = 4'b0001; lock = 4'b0001; addr = $urandom;
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            req = (c == 2) ? 4'b0101 : 4'b0001;
            @(negedge clk); model_eval();
            n_tests++; if (gnt1 !== 4'b0001) begin n_fail++; $display("FAIL abandon_gnt c%0d: got %b expected 0001", c, gnt1); end
            n_tests++; if (rv1 !== exp_rv1 || rv1[2] !== 1'b0) begin n_fail++; $display("FAIL abandon_rd_valid c%0d: got %b expected %b", c, rv1, exp_rv1); end
            advance();
        end
        // Lock continues from requester 0; a new rival must still wait out the burst.
        req = 4'b0011;
        @(negedge clk); model_eval();
        n_tests++; if (gnt1 !== exp_gnt || gnt1 !== 4'b0001) begin n_fail++; $display("FAIL abandon_state: got %b expected %b", gnt1, exp_gnt); end
        advance();
    endtask

    task automatic test_reset_midread();
        req = 4'b0100; lock = 4'b0000; addr = $urandom;
        apply_reset();
        @(negedge clk); model_eval();
        n_tests++; if (gnt1 !== 4'b0100) begin n_fail++; $display("FAIL midread_gnt: got %b expected 0100", gnt1); end
        advance();
        reset_n = 1'b0; model_reset();
        @(negedge clk);
        n_tests++; if (rv1 !== 4'b0000) begin n_fail++; $display("FAIL midread_rd_valid: got %b expected 0000", rv1); end
        @(posedge clk); #1;
        req = 4'b1111; reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); model_eval();
            if (c == 0) begin
                n_tests++; if (gnt1 !== 4'b0001) begin n_fail++; $display("FAIL midread_rr_ptr: got %b expected 0001", gnt1); end
            end
            n_tests++; if (rv1 !== exp_rv1 || rv3 !== exp_rv3) begin n_fail++; $display("FAIL midread_return c%0d: got %b/%b expected %b/%b", c, rv1, rv3, exp_rv1, exp_rv3); end
            advance();
        end
    endtask

    task automatic test_rom_lat3();
        req = 4'b0101; lock = 4'b0000; addr = $urandom;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); model_eval();
            if (c >= 3) begin
                n_tests++; if (rv3 !== ((c % 2 == 1) ? 4'b0001 : 4'b0100)) begin n_fail++; $display("FAIL lat3_rd_valid c%0d: got %b", c, rv3); end
                n_tests++; if (rd3 !== exp_rd3) begin n_fail++; $display("FAIL lat3_rd_data c%0d: got %h expected %h", c, rd3, exp_rd3); end
            end else begin
                n_tests++; if (rv3 !== 4'b0000) begin n_fail++; $display("FAIL lat3_early c%0d: got %b expected 0000", c, rv3); end
            end
            advance();
        end
    endtask

    task automatic test_random();
        req = 4'b0000; lock = 4'b0000; addr = $urandom;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk); model_eval();
            n_tests++;
            if (gnt1 !== exp_gnt || gnt3 !== exp_gnt || ra1 !== exp_addr || ra3 !== exp_addr) begin
                n_fail++; $display("FAIL rand_gnt c%0d: got %b/%b addr %h expected %b addr %h", c, gnt1, gnt3, ra1, exp_gnt, exp_addr);
            end
            n_tests++;
            if (rv1 !== exp_rv1 || rv3 !== exp_rv3 || (exp_rv1 != 0 && rd1 !== exp_rd1) || (exp_rv3 != 0 && rd3 !== exp_rd3)) begin
                n_fail++; $display("FAIL rand_read c%0d: got %b/%h %b/%h expected %b/%h %b/%h", c, rv1, rd1, rv3, rd3, exp_rv1, exp_rd1, exp_rv3, exp_rd3);
            end
            advance();
            for (int i = 0; i < 4; i++) begin
                if (req[i] && m_win != i) begin
                    if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                end else begin
                    req[i]         = ($urandom_range(0, 3) != 0);
                    lock[i]        = ($urandom_range(0, 2) != 0);
                    addr[i*8 +: 8] = 8'($urandom);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; req = '0; lock = '0; addr = '0;
        test_reset();
        test_round_robin();
        test_burst();
        test_abandon();
        test_reset_midread();
        test_rom_lat3();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
